im_fetch_unit: RTL and testbench
================================

IM_FETCH_UNIT -- requirements
Module: im_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in bytes; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter ADDR_W, default 32: width of the fetch address and load address.
REQ-003 Parameter LAT, default 1: fetch latency in clock edges; legal range 1..4.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 IAddr  input  ADDR_W  byte address of the instruction to fetch.
REQ-007 Req  input  1  fetch request (level).
REQ-008 LdEn  input  1  program-load byte write enable.
REQ-009 LdAddr  input  ADDR_W  program-load byte address.
REQ-010 LdByte  input  8  program-load byte data.
REQ-011 Busy  output  1  a fetch is in flight.
REQ-012 Valid  output  1  one-cycle pulse: DataOut/Fault carry a completed fetch.
REQ-013 DataOut  output  32  fetched instruction word.
REQ-014 Fault  output  1  the completed fetch was illegal.

Function
REQ-015 Storage SHALL be DEPTH bytes, byte-addressed, initialised to 0x00 at time zero and never cleared by Reset.
REQ-016 A word read SHALL be big-endian: DataOut = {mem[A], mem[A+1], mem[A+2], mem[A+3]}, where A is the latched address.
REQ-017 FSM states SHALL be IDLE, WAIT and RESP.
REQ-018 Accept condition: (state IDLE or RESP) and Req=1 and LdEn=0; on accept, latch IAddr; later IAddr changes SHALL NOT affect that fetch.
REQ-019 Accept edge k: Valid=1 during exactly the cycle following edge k+LAT.
  - LAT=1: IDLE->RESP.
  - LAT>1: IDLE->WAIT, count LAT-1 edges, WAIT->RESP.
REQ-020 RESP lasts one cycle; next state is WAIT/RESP on a new accept, otherwise IDLE; back-to-back throughput is one fetch per LAT cycles.
REQ-021 Busy=1 in WAIT, and in IDLE/RESP on the cycle an accept is pending; Busy=0 otherwise.
REQ-022 Illegal fetch: A[1:0]!=0 (misaligned) or A+3 >= DEPTH (out of range).
  - Fault=1 with Valid.
  - DataOut=0xFC000000 (halt encoding).
  - No memory read.
REQ-023 Legal fetch: Fault=0 with Valid.
REQ-024 DataOut and Fault SHALL be registered; they hold their value until the next Valid.
REQ-025 Load: LdEn=1 in IDLE or RESP with no fetch in flight writes LdByte to mem[LdAddr] on the edge.
  - Ignored if LdAddr >= DEPTH.
  - Ignored while in WAIT.
REQ-026 LdEn=1 and Req=1 in the same cycle: the load wins and Req is not accepted that cycle; Req is re-evaluated next cycle.
REQ-027 A load to a byte in the same cycle as an accept is impossible (REQ-018); a fetch returns memory contents as of its accept edge.
REQ-028 Address arithmetic SHALL be ADDR_W bits unsigned; A+3 SHALL be computed without wrap (ADDR_W+1 bits) so addresses near 2^ADDR_W fault.

Reset
REQ-029 While Reset=0:
  - state=IDLE.
  - Busy=0, Valid=0, Fault=0, DataOut=0x00000000.
  - latency counter=0.
  - latched address=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the fetch with no Valid pulse; memory contents SHALL be preserved.
REQ-031 The first accept is permitted on the first rising edge with Reset=1.

Verification
REQ-032 LAT=1: load 0x48,0x01,0x00,0x08 at 0x64..0x67; Req with IAddr=0x64 -> Valid one cycle after accept, DataOut=0x48010008, Fault=0.
REQ-033 LAT=3: Req with IAddr=0x64, then IAddr changed to 0x68 the next cycle -> Busy high 3 cycles, Valid at accept+3, DataOut=0x48010008.
REQ-034 IAddr=0x66 -> Fault=1, DataOut=0xFC000000; IAddr=0xFE with DEPTH=256 -> Fault=1.
REQ-035 LdEn=1 and Req=1 together (LdAddr=0x70, LdByte=0xAA; IAddr=0x70) -> byte written, fetch accepted one cycle later, DataOut[31:24]=0xAA.
REQ-036 Reset pulsed low during WAIT (LAT=4) -> Valid never pulses, all outputs 0, then a re-fetch of 0x64 returns 0x48010008.
REQ-037 Req held high, LAT=2, addresses 0x64 then 0x68 -> Valid every 2 cycles with correct words; LdEn during WAIT leaves memory unchanged.

Source files
------------

// File: rtl/im_fetch_unit.sv
// Instruction-memory fetch unit: byte-wide program-load port plus a fixed-latency,
// big-endian word fetch that reports misaligned or out-of-range addresses as faults.
module im_fetch_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int LAT    = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic              Req,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [7:0]        LdByte,
  output logic              Busy,
  output logic              Valid,
  output logic [31:0]       DataOut,
  output logic              Fault
);
  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  WAIT_LAST = 2'(LAT - 2);
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem [DEPTH];
  logic              can_act, accept, load, fault;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       word;

  // The +3 end check is done one bit wider so addresses near the top of the space fault.
  always_comb begin
    idx   = addr[IDX_W-1:0];
    fault = (addr[1:0] != 2'b00) ||
            (({1'b0, addr} + (ADDR_W+1)'(3)) >= (ADDR_W+1)'(DEPTH));
    word  = '0;
    if (!fault)
      word = {mem[idx], mem[IDX_W'(idx + 1)], mem[IDX_W'(idx + 2)], mem[IDX_W'(idx + 3)]};
  end

  always_comb begin
    state_nxt = state;
    can_act   = Reset && (state != WAIT);
    accept    = can_act && Req && !LdEn;
    load      = can_act && LdEn && ({1'b0, LdAddr} < (ADDR_W+1)'(DEPTH));
    Busy      = accept || (state == WAIT);
    case (state)
      WAIT: begin
        if (cnt == WAIT_LAST)
          state_nxt = RESP;
      end
      default: begin
        if (accept)
          state_nxt = (LAT == 1) ? RESP : WAIT;
        else
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The word is captured on the edge that leaves RESP, so Valid lands LAT edges after accept.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt     <= '0;
      addr    <= '0;
      Valid   <= 1'b0;
      DataOut <= '0;
      Fault   <= 1'b0;
    end else begin
      Valid <= (state == RESP);
      if (accept) begin
        addr <= IAddr;
        cnt  <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 2'd1;
      end
      if (state == RESP) begin
        DataOut <= fault ? HALT_WORD : word;
        Fault   <= fault;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load)
      mem[LdAddr[IDX_W-1:0]] <= LdByte;
  end

endmodule

// File: tb/tb_im_fetch_unit.sv
// Bench for im_fetch_unit: four instances (LAT 1..4) share one stimulus stream and
// are compared every cycle against a transaction-level reference model.
module tb_im_fetch_unit;
  localparam int DEPTH = 256;
  localparam int NLANE = 4;

  logic        CLK    = 1'b0;
  logic        Reset  = 1'b1;
  logic [31:0] IAddr  = '0;
  logic        Req    = 1'b0;
  logic        LdEn   = 1'b0;
  logic [31:0] LdAddr = '0;
  logic [7:0]  LdByte = '0;

  logic        busy    [NLANE];
  logic        valid   [NLANE];
  logic [31:0] dataOut [NLANE];
  logic        fault   [NLANE];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NLANE; g++) begin : gLane
    im_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .LAT(g + 1)) dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .IAddr  (IAddr),
      .Req    (Req),
      .LdEn   (LdEn),
      .LdAddr (LdAddr),
      .LdByte (LdByte),
      .Busy   (busy[g]),
      .Valid  (valid[g]),
      .DataOut(dataOut[g]),
      .Fault  (fault[g])
    );
  end

  // Reference model: an accept in cycle c makes the lane free again at c+LAT and
  // delivers its response (computed from memory at accept time) in cycle c+LAT+1.
  typedef struct {
    int          lane;
    int          due;
    logic [31:0] data;
    logic        flt;
  } resp_t;

  resp_t       pend [$];
  logic [7:0]  refMem  [NLANE][DEPTH];
  int          freeAt  [NLANE];
  logic [31:0] expData [NLANE];
  logic        expFault[NLANE];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string tag, input int lane, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s lane%0d cycle %0d: observed %h expected %h", tag, lane, cyc, obs, exp);
    end
  endtask

  function automatic void fetchWord(input int lane, input logic [31:0] a,
                                    output logic [31:0] w, output logic f);
    longint unsigned ext;
    ext = {32'd0, a};
    f   = (a % 4 != 0) || (ext + 3 >= DEPTH);
    w   = 32'hFC00_0000;
    if (!f)
      w = {refMem[lane][a], refMem[lane][a + 1], refMem[lane][a + 2], refMem[lane][a + 3]};
  endfunction

  function automatic void modelReset();
    pend.delete();
    for (int i = 0; i < NLANE; i++) begin
      freeAt[i]   = 0;
      expData[i]  = '0;
      expFault[i] = 1'b0;
    end
  endfunction

  task automatic checkCycle();
    logic        expValid, expBusy, acc, ld, f;
    logic [31:0] w;
    for (int i = 0; i < NLANE; i++) begin
      expValid = 1'b0;
      expBusy  = 1'b0;
      acc      = 1'b0;
      ld       = 1'b0;
      if (Reset) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].lane == i && pend[k].due == cyc) begin
            expValid    = 1'b1;
            expData[i]  = pend[k].data;
            expFault[i] = pend[k].flt;
            pend.delete(k);
            break;
          end
        end
        acc     = (cyc >= freeAt[i]) && Req && !LdEn;
        ld      = (cyc >= freeAt[i]) && LdEn;
        expBusy = acc || (cyc < freeAt[i]);
      end
      checkOutput("busy",  i, 32'(busy[i]),  32'(expBusy));
      checkOutput("valid", i, 32'(valid[i]), 32'(expValid));
      checkOutput("data",  i, dataOut[i],    expData[i]);
      checkOutput("fault", i, 32'(fault[i]), 32'(expFault[i]));
      if (acc) begin
        fetchWord(i, IAddr, w, f);
        pend.push_back('{i, cyc + i + 2, w, f});
        freeAt[i] = cyc + i + 1;
      end
      if (ld && LdAddr < DEPTH)
        refMem[i][LdAddr] = LdByte;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    checkCycle();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] iaddr, input logic lden,
                               input logic [31:0] ldaddr, input logic [7:0] ldbyte,
                               input int n);
    Req    = req;
    IAddr  = iaddr;
    LdEn   = lden;
    LdAddr = ldaddr;
    LdByte = ldbyte;
    repeat (n) tick();
  endtask

  task automatic checkAll(input string tag, input logic [31:0] data, input logic flt);
    for (int i = 0; i < NLANE; i++) begin
      checkOutput({tag, "_data"},  i, dataOut[i], data);
      checkOutput({tag, "_fault"}, i, 32'(fault[i]), 32'(flt));
    end
  endtask

  task automatic fetchAndSettle(input logic [31:0] a);
    applyStimulus(1'b1, a, 1'b0, 32'h0, 8'h00, 1);
    applyStimulus(1'b0, a + 4, 1'b0, 32'h0, 8'h00, 7);
  endtask

  logic [7:0] image [12] = '{8'h48, 8'h01, 8'h00, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    for (int i = 0; i < NLANE; i++)
      for (int j = 0; j < DEPTH; j++)
        refMem[i][j] = 8'h00;
    modelReset();
    #1 Reset = 1'b0;
    applyStimulus(1'b1, 32'h64, 1'b0, 32'h0, 8'h00, 3);
    Reset = 1'b1;

    for (int b = 0; b < 8; b++)
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h64 + b, image[b], 1);
    for (int b = 0; b < 4; b++)
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hFC + b, image[8 + b], 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h120, 8'h55, 1);

    // Address changes the cycle after accept must not disturb the fetch.
    applyStimulus(1'b1, 32'h64, 1'b0, 32'h0, 8'h00, 1);
    applyStimulus(1'b0, 32'h68, 1'b0, 32'h0, 8'h00, 7);
    checkAll("word64", 32'h4801_0008, 1'b0);
    fetchAndSettle(32'h68);
    checkAll("word68", 32'h1234_5678, 1'b0);
    fetchAndSettle(32'h66);
    checkAll("misalign", 32'hFC00_0000, 1'b1);
    fetchAndSettle(32'hFE);
    checkAll("rangeFE", 32'hFC00_0000, 1'b1);
    fetchAndSettle(32'hFC);
    checkAll("lastWord", 32'hDEAD_BEEF, 1'b0);
    fetchAndSettle(32'h100);
    checkAll("range100", 32'hFC00_0000, 1'b1);
    fetchAndSettle(32'hFFFF_FFFC);
    checkAll("wrapTop", 32'hFC00_0000, 1'b1);

    // Load and request together: the load wins, the request is taken next cycle.
    applyStimulus(1'b1, 32'h70, 1'b1, 32'h70, 8'hAA, 1);
    applyStimulus(1'b1, 32'h70, 1'b0, 32'h0, 8'h00, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 7);
    for (int i = 0; i < NLANE; i++)
      checkOutput("ldReqTop", i, 32'(dataOut[i][31:24]), 32'hAA);

    // Reset while the longer-latency lanes are waiting abandons their fetches.
    applyStimulus(1'b1, 32'h68, 1'b0, 32'h0, 8'h00, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1);
    Reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 2);
    checkAll("inReset", 32'h0, 1'b0);
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 6);
    checkAll("noLatePulse", 32'h0, 1'b0);
    fetchAndSettle(32'h64);
    checkAll("afterReset", 32'h4801_0008, 1'b0);

    // Held request streams back to back; a load mid-stream only lands on idle lanes.
    applyStimulus(1'b1, 32'h64, 1'b0, 32'h0, 8'h00, 2);
    applyStimulus(1'b1, 32'h68, 1'b0, 32'h0, 8'h00, 2);
    applyStimulus(1'b1, 32'h64, 1'b1, 32'h65, 8'hEE, 1);
    applyStimulus(1'b1, 32'h68, 1'b0, 32'h0, 8'h00, 3);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 7);
    fetchAndSettle(32'h64);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        Reset = 1'b0;
        modelReset();
      end else begin
        Reset = 1'b1;
      end
      applyStimulus($urandom_range(0, 2) != 0,
                    ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h103)),
                    $urandom_range(0, 3) == 0,
                    32'($urandom_range(0, 32'h10F)),
                    8'($urandom), 1);
    end
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
